// File: rtl/gpu_cmd_frame_port_pkg.sv
// Shared types for the GPU command frame port: parser states and FIFO entry tag layout.
package gpu_cmd_frame_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DISCARD = 2'd2
    } parse_state_t;

    // Tag stored above the data word in every FIFO entry.
    typedef struct packed {
        logic first;
        logic last;
    } cmd_tag_t;

    localparam int TAG_W = $bits(cmd_tag_t);

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/gpu_cmd_frame_port_if.sv
// Controller-side link of the command frame port: tagged word stream out, read-back and status in.
interface gpu_cmd_frame_port_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] cmd_word;
    logic              cmd_first;
    logic              cmd_last;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              frame_rendering;
    logic              gpu_busy;

    modport master (
        output cmd_word, cmd_first, cmd_last, cmd_valid,
        input  cmd_ready, rd_data, rd_valid, frame_rendering, gpu_busy
    );

    modport slave (
        input  cmd_word, cmd_first, cmd_last, cmd_valid,
        output cmd_ready, rd_data, rd_valid, frame_rendering, gpu_busy
    );
endinterface

// File: rtl/gpu_cmd_frame_port_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; simultaneous push and pop always honoured.
module gpu_cmd_frame_port_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             empty;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage has no reset; only pointers and count need a known value, and leaving
    // the array unreset lets it map onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign count    = count_q;
endmodule

// File: rtl/gpu_cmd_frame_port.sv
// GPU command front end: synchronises the pad bus, parses length-prefixed frames into a tagged FIFO,
// and drives controller read-back data onto the pad.
module gpu_cmd_frame_port
    import gpu_cmd_frame_port_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int LEN_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 gpu_clk,
    input  logic                 rst,
    input  logic                 cmd_clk_pin,
    input  logic                 output_enable_pin,
    input  logic [DATA_W-1:0]    cmd_data_in,
    output logic [DATA_W-1:0]    cmd_data_out,
    output logic                 cmd_data_oe,
    output logic                 ready_busy,
    output logic                 overflow_err,
    output logic                 drop_err,
    input  logic                 err_clear,
    gpu_cmd_frame_port_if.master ctrl
);
    localparam int ENTRY_W = DATA_W + TAG_W;
    localparam int CNT_W   = cnt_width(FIFO_DEPTH);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] oe_sync;
    logic [DATA_W-1:0]      data_sync [SYNC_STAGES];
    logic                   clk_prev;
    logic                   oe_s;
    logic                   strobe_edge;

    logic                   acc_valid;
    logic [DATA_W-1:0]      acc_word;
    logic [LEN_W-1:0]       acc_len;

    parse_state_t           state, state_n;
    logic [LEN_W-1:0]       remaining, remaining_n;
    logic                   push_q, push_n;
    cmd_tag_t               push_tag_q, push_tag_n;
    logic [DATA_W-1:0]      push_word_q;
    logic                   drop_set, ovf_set;

    logic [ENTRY_W-1:0]     head;
    logic [CNT_W-1:0]       fifo_count;
    logic [CNT_W-1:0]       occ;
    logic                   cmd_valid;
    logic                   pop;
    cmd_tag_t               head_tag;
    logic [DATA_W-1:0]      rd_reg;

    // NOTE: every clocked block uses non-blocking assignments so each flop samples pre-edge values.
    always_ff @(posedge gpu_clk) begin
        if (!rst) begin
            clk_sync  <= '0;
            oe_sync   <= '0;
            clk_prev  <= 1'b0;
            acc_valid <= 1'b0;
            acc_word  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
        end else begin
            clk_sync     <= {clk_sync[SYNC_STAGES-2:0], cmd_clk_pin};
            oe_sync      <= {oe_sync[SYNC_STAGES-2:0], output_enable_pin};
            data_sync[0] <= cmd_data_in;
            for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
            clk_prev     <= clk_sync[SYNC_STAGES-1];
            // Strobes seen while the pad is in read-back mode are not words.
            acc_valid    <= strobe_edge & ~oe_s;
            acc_word     <= data_sync[SYNC_STAGES-1];
        end
    end

    assign oe_s        = oe_sync[SYNC_STAGES-1];
    assign strobe_edge = clk_sync[SYNC_STAGES-1] & ~clk_prev;
    assign acc_len     = acc_word[LEN_W-1:0];

    // Occupancy includes the word staged for the next FIFO write.
    assign occ        = fifo_count + CNT_W'(push_q);
    assign ready_busy = (state == ST_IDLE) & ~ctrl.frame_rendering & ~ctrl.gpu_busy
                        & (occ <= CNT_W'(FIFO_DEPTH - 2));

    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        push_n      = 1'b0;
        push_tag_n  = '0;
        drop_set    = 1'b0;
        ovf_set     = 1'b0;
        if (acc_valid) begin
            case (state)
                ST_IDLE: begin
                    if (!ready_busy) begin
                        drop_set = 1'b1;
                    end else begin
                        push_n          = 1'b1;
                        push_tag_n.first = 1'b1;
                        push_tag_n.last  = (acc_len == '0);
                        if (acc_len != '0) begin
                            remaining_n = acc_len;
                            state_n     = ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    remaining_n = remaining - LEN_W'(1);
                    if (occ == CNT_W'(FIFO_DEPTH)) begin
                        ovf_set = 1'b1;
                        state_n = (remaining == LEN_W'(1)) ? ST_IDLE : ST_DISCARD;
                    end else begin
                        push_n         = 1'b1;
                        push_tag_n.last = (remaining == LEN_W'(1));
                        if (remaining == LEN_W'(1)) state_n = ST_IDLE;
                    end
                end
                ST_DISCARD: begin
                    remaining_n = remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge gpu_clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            remaining    <= '0;
            push_q       <= 1'b0;
            push_tag_q   <= '0;
            push_word_q  <= '0;
            overflow_err <= 1'b0;
            drop_err     <= 1'b0;
            rd_reg       <= '0;
        end else begin
            state       <= state_n;
            remaining   <= remaining_n;
            push_q      <= push_n;
            push_tag_q  <= push_tag_n;
            push_word_q <= acc_word;
            if (ovf_set)        overflow_err <= 1'b1;
            else if (err_clear) overflow_err <= 1'b0;
            if (drop_set)       drop_err <= 1'b1;
            else if (err_clear) drop_err <= 1'b0;
            if (ctrl.rd_valid)  rd_reg <= ctrl.rd_data;
        end
    end

    gpu_cmd_frame_port_fifo #(
        .W     (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (gpu_clk),
        .rst       (rst),
        .push      (push_q),
        .push_data ({push_tag_q, push_word_q}),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count)
    );

    assign cmd_valid      = (fifo_count != '0);
    assign pop            = cmd_valid & ctrl.cmd_ready;
    assign head_tag       = cmd_tag_t'(head[ENTRY_W-1 -: TAG_W]);
    assign ctrl.cmd_valid = cmd_valid;
    assign ctrl.cmd_word  = cmd_valid ? head[DATA_W-1:0] : '0;
    assign ctrl.cmd_first = cmd_valid & head_tag.first;
    assign ctrl.cmd_last  = cmd_valid & head_tag.last;

    assign cmd_data_oe  = oe_s;
    assign cmd_data_out = rd_reg;
endmodule
